// File: rtl/lcd_frame_arbiter.sv
// lcd_frame_arbiter
// Shares the single lcd_ctrl byte-stream path between two byte-stream producers.
// Whole frames are granted at a time, never interleaving bytes of two sources,
// and ties are broken round-robin so that two busy sources alternate frames.
// While a frame is in flight the datapath is a purely combinational mux, so
// the arbiter adds no latency between a source and lcd_ctrl.
module lcd_frame_arbiter #(
    parameter int FRAME_BYTES = 1024,
    parameter int CNT_W       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [7:0]       data0,
    input  logic             valid0,
    input  logic [7:0]       data1,
    input  logic             valid1,
    input  logic             en_tran,
    output logic             en0,
    output logic             en1,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] byte_cnt
);

    // IDLE waits for a request, XFER streams one frame, DONE is the single
    // cycle that gives lcd_ctrl time to re-address page 0 before the next frame.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Index of the final byte of a frame; the counter never goes past it.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       grant_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             last;       // index of the source that owned the previous frame
    logic             last_nxt;
    logic [1:0]       pick;       // owner chosen from the current request pattern
    logic             beat;       // a byte is handed to lcd_ctrl this cycle

    // A byte moves only while streaming and only when both ends agree.
    assign beat = busy & en_tran & data_valid;

    // Round-robin choice: a lone requester always wins, a tie goes to the
    // source that did not own the previous frame.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        pick = 2'b00;
        unique case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

    // State register: FSM state, owner, frame byte counter and fairness memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            grant    <= 2'b00;
            byte_cnt <= '0;
            last     <= 1'b1;       // source 0 wins the first tie after reset
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the values from before this edge, independent of statement order.
            state    <= state_nxt;
            grant    <= grant_nxt;
            byte_cnt <= cnt_nxt;
            last     <= last_nxt;
        end
    end

    // Next-state logic: frame sequencing, owner selection and byte counting.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        cnt_nxt   = byte_cnt;
        last_nxt  = last;
        unique case (state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    state_nxt = S_XFER;
                    grant_nxt = pick;
                    cnt_nxt   = '0;
                end
            end
            S_XFER: begin
                // Requests are ignored here: a started frame always completes.
                if (beat) begin
                    if (byte_cnt == LAST_IDX) begin
                        state_nxt = S_DONE;
                        grant_nxt = 2'b00;
                        cnt_nxt   = '0;
                        last_nxt  = grant[1];
                    end else begin
                        cnt_nxt = byte_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                grant_nxt = 2'b00;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                grant_nxt = 2'b00;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: zero-latency mux from the owner to lcd_ctrl while streaming;
    // the ungranted source sees no enable and its byte never reaches data_out.
    always_comb begin
        busy       = (state == S_XFER);
        frame_done = (state == S_DONE);
        data_out   = 8'h00;
        data_valid = 1'b0;
        en0        = 1'b0;
        en1        = 1'b0;
        if (state == S_XFER) begin
            data_out   = grant[1] ? data1 : data0;
            data_valid = (grant[0] & valid0) | (grant[1] & valid1);
            en0        = en_tran & grant[0];
            en1        = en_tran & grant[1];
        end
    end

    // Structural invariants: exactly one owner while streaming, none otherwise,
    // and the counter stays inside the frame.
    a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        (state == S_XFER) |-> $onehot(grant));
    a_grant_idle : assert property (@(posedge clk) disable iff (!rst_n)
        (state != S_XFER) |-> (grant == 2'b00));
    a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
        byte_cnt <= LAST_IDX);

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Testbench for lcd_frame_arbiter.
// Two behavioural byte sources feed a FRAME_BYTES=4 instance; the frame order
// they should see is derived from the round-robin rules up front and queued as
// expected bytes, and an independent monitor pops one entry per accepted byte.
// A second instance with 1024-byte frames covers the full-size counter.
module tb_lcd_frame_arbiter;

    localparam int FB = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Small instance signals
    logic [1:0]    req;
    logic [7:0]    data0, data1;
    logic          valid0, valid1, en_tran;
    logic          en0, en1, data_valid, busy, frame_done;
    logic [7:0]    data_out;
    logic [1:0]    grant;
    logic [CW-1:0] byte_cnt;

    // Full-size instance signals
    logic [1:0] req_b;
    logic [7:0] data0_b, data1_b;
    logic       valid0_b, valid1_b, en_tran_b;
    logic       en0_b, en1_b, data_valid_b, busy_b, frame_done_b;
    logic [7:0] data_out_b;
    logic [1:0] grant_b;
    logic [9:0] byte_cnt_b;

    lcd_frame_arbiter #(.FRAME_BYTES(FB), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .data0(data0), .valid0(valid0), .data1(data1), .valid1(valid1),
        .en_tran(en_tran), .en0(en0), .en1(en1),
        .data_out(data_out), .data_valid(data_valid), .grant(grant),
        .busy(busy), .frame_done(frame_done), .byte_cnt(byte_cnt)
    );

    lcd_frame_arbiter #(.FRAME_BYTES(1024), .CNT_W(10)) u_big (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .data0(data0_b), .valid0(valid0_b), .data1(data1_b), .valid1(valid1_b),
        .en_tran(en_tran_b), .en0(en0_b), .en1(en1_b),
        .data_out(data_out_b), .data_valid(data_valid_b), .grant(grant_b),
        .busy(busy_b), .frame_done(frame_done_b), .byte_cnt(byte_cnt_b)
    );

    typedef struct {
        logic        src;
        logic [7:0]  data;
        int unsigned idx;
    } exp_t;

    exp_t       sb[$];          // expected accepted bytes, in order
    logic [7:0] src_q0[$];      // bytes source 0 still has to send
    logic [7:0] src_q1[$];
    int         frames_left0, frames_left1;
    int         pos0, pos1;     // byte position inside the source's current frame
    logic       model_last = 1'b1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every accepted byte with the scoreboard and checks the
    // DONE pulse and the idle cycle that must follow every frame.
    logic expect_done = 1'b0;
    logic expect_gap  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        logic nd, ng;
        if (!rst_n) begin
            expect_done = 1'b0;
            expect_gap  = 1'b0;
        end else begin
            nd = 1'b0;
            ng = 1'b0;
            check("frame_done", 32'(frame_done), 32'(expect_done));
            if (expect_done) begin
                check("done_grant", 32'(grant), 32'd0);
                check("done_outputs", 32'({busy, data_valid, en1, en0}), 32'd0);
                ng = 1'b1;
            end
            if (expect_gap) check("gap_busy", 32'(busy), 32'd0);
            if (!busy) check("idle_outputs", 32'({data_valid, en1, en0, data_out, byte_cnt}), 32'd0);
            if (data_valid && en_tran) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("data_out", 32'(data_out), 32'(e.data));
                    check("beat_grant", 32'(grant), e.src ? 32'd2 : 32'd1);
                    check("beat_en", 32'({en1, en0}), e.src ? 32'd2 : 32'd1);
                    check("byte_cnt", 32'(byte_cnt), e.idx);
                    if (e.idx == FB - 1) nd = 1'b1;
                end
            end
            expect_done = nd;
            expect_gap  = ng;
        end
    end

    task automatic clear_sources();
        sb.delete();
        src_q0.delete();
        src_q1.delete();
        frames_left0 = 0;
        frames_left1 = 0;
        pos0 = 0;
        pos1 = 0;
        req = 2'b00;
        valid0 = 1'b0;
        valid1 = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;
        en_tran = 1'b0;
    endtask

    // Asynchronous reset mid-cycle: outputs must drop immediately.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_outputs", 32'({busy, frame_done, data_valid, en1, en0}), 32'd0);
        check("rst_data_cnt", 32'({data_out, byte_cnt}), 32'd0);
        clear_sources();
        model_last = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Queue n0/n1 frames, predict the frame order from the round-robin rules,
    // then run the sources until everything has been delivered.
    task automatic run_test(input int n0, input int n1, input int vpct, input int epct,
                            input bit drop0, input int abort_after, input bit pattern);
        int   r0, r1, o0, o1, taken, c;
        logic pick, first_pick, take0, take1, finished;
        logic [7:0] b;
        for (int f = 0; f < n0; f++)
            for (int i = 0; i < FB; i++) begin
                b = pattern ? 8'(8'hA0 + i) : 8'($urandom);
                src_q0.push_back(b);
            end
        for (int f = 0; f < n1; f++)
            for (int i = 0; i < FB; i++) src_q1.push_back(8'($urandom));
        r0 = n0; r1 = n1; o0 = 0; o1 = 0;
        first_pick = 1'b0;
        for (int k = 0; r0 > 0 || r1 > 0; k++) begin
            if (r0 > 0 && r1 > 0) pick = ~model_last;
            else                  pick = (r0 > 0) ? 1'b0 : 1'b1;
            if (k == 0) first_pick = pick;
            for (int i = 0; i < FB; i++) begin
                if (pick) sb.push_back('{src: 1'b1, data: src_q1[o1 + i], idx: i});
                else      sb.push_back('{src: 1'b0, data: src_q0[o0 + i], idx: i});
            end
            if (pick) begin o1 += FB; r1--; end
            else      begin o0 += FB; r0--; end
            model_last = pick;
        end
        frames_left0 = n0;
        frames_left1 = n1;
        pos0 = 0;
        pos1 = 0;
        taken = 0;
        finished = 1'b0;
        req = {frames_left1 > 0, frames_left0 > 0};
        for (c = 0; c < 3000 && !finished; c++) begin
            valid0 = (frames_left0 > 0) && ($urandom_range(99) < vpct);
            valid1 = (frames_left1 > 0) && ($urandom_range(99) < vpct);
            data0  = valid0 ? src_q0[0] : 8'($urandom);
            data1  = valid1 ? src_q1[0] : 8'($urandom);
            en_tran = ($urandom_range(99) < epct);
            @(negedge clk);
            if (n0 + n1 > 0) begin
                if (c == 0) check("grant_before_edge", 32'(grant), 32'd0);
                if (c == 1) check("grant_latency", 32'(grant), first_pick ? 32'd2 : 32'd1);
            end
            take0 = en0 & valid0;
            take1 = en1 & valid1;
            @(posedge clk);
            #1;
            if (take0) begin
                void'(src_q0.pop_front());
                taken++;
                pos0++;
                if (pos0 == FB) begin pos0 = 0; frames_left0--; end
            end
            if (take1) begin
                void'(src_q1.pop_front());
                taken++;
                pos1++;
                if (pos1 == FB) begin pos1 = 0; frames_left1--; end
            end
            req[0] = (frames_left0 > 0) && !(drop0 && frames_left0 == 1 && pos0 >= 2);
            req[1] = (frames_left1 > 0);
            if (abort_after >= 0 && taken == abort_after) begin
                do_reset();
                return;
            end
            if (frames_left0 == 0 && frames_left1 == 0 && sb.size() == 0) finished = 1'b1;
        end
        if (!finished) begin
            check("timeout", 32'd1, 32'd0);
            do_reset();
            return;
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        en_tran = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int beats, dones, n0, n1;
        clear_sources();
        req_b = 2'b00; data0_b = 8'h00; valid0_b = 1'b0;
        data1_b = 8'h00; valid1_b = 1'b0; en_tran_b = 1'b0;

        // Reset state while rst_n is held low
        #3;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_outputs", 32'({busy, frame_done, data_valid, en1, en0, data_out, byte_cnt}), 32'd0);
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single source, steady handshake, bytes A0..A3
        run_test(1, 0, 100, 100, 1'b0, -1, 1'b1);
        // 2: both requesting from reset -> 0,1,0,1,...
        do_reset();
        run_test(3, 3, 100, 100, 1'b0, -1, 1'b0);
        // 3: stalls on en_tran and valid
        run_test(2, 1, 60, 50, 1'b0, -1, 1'b0);
        // 4: owner drops req mid-frame
        run_test(1, 0, 100, 100, 1'b1, -1, 1'b1);
        // 5: reset after two bytes, then a tie must go to source 0
        run_test(1, 1, 100, 100, 1'b0, 2, 1'b0);
        run_test(1, 1, 100, 100, 1'b0, -1, 1'b0);

        // Randomized mixes
        for (int t = 0; t < 8; t++) begin
            n0 = $urandom_range(3);
            n1 = (n0 == 0) ? 1 + $urandom_range(2) : $urandom_range(3);
            run_test(n0, n1, 30 + $urandom_range(70), 30 + $urandom_range(70),
                     1'($urandom_range(1)), -1, 1'b0);
        end

        // 6: full-size frame from source 1 only
        beats = 0;
        dones = 0;
        @(posedge clk);
        #1;
        req_b = 2'b10;
        valid1_b = 1'b1;
        en_tran_b = 1'b1;
        data1_b = 8'h00;
        for (int cyc = 0; cyc < 1100; cyc++) begin
            @(negedge clk);
            if (frame_done_b) dones++;
            if (data_valid_b && en_tran_b) begin
                check("big_data", 32'(data_out_b), 32'(beats[7:0]));
                if (beats == 1023) check("big_cnt_last", 32'(byte_cnt_b), 32'd1023);
                beats++;
            end
            @(posedge clk);
            #1;
            if (beats >= 1) req_b = 2'b00;
            valid1_b = (beats < 1024);
            data1_b = beats[7:0];
        end
        check("big_beats", 32'(beats), 32'd1024);
        check("big_done_pulses", 32'(dones), 32'd1);
        check("big_cnt_after", 32'(byte_cnt_b), 32'd0);
        check("big_idle", 32'({busy_b, grant_b}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
